// File: rtl/cordic_sincos_folded.sv
// Iterative CORDIC rotation engine returning cos/sin of a signed fixed-point angle.
// FOLD micro-iterations run per enabled clock; quadrant folding extends convergence to [-2,2) rad.
`timescale 1ns/1ps
module cordic_sincos_folded #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned FRAC  = 22,
  parameter int unsigned ITER  = 16,
  parameter int unsigned FOLD  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clk_en,
  input  logic             i_start,
  input  logic             i_res_sel,
  input  logic [WIDTH-1:0] i_z_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_cos_out,
  output logic [WIDTH-1:0] o_sin_out,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned IW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITER + 1);
  localparam int unsigned TN = 2 ** CW;
  localparam real         PI_R = 3.14159265358979323846;

  function automatic real pow2_neg(input int n);
    real t;
    t = 1.0;
    for (int k = 0; k < n; k++) t = t / 2.0;
    return t;
  endfunction

  function automatic real sqrt_r(input real a);
    real s;
    s = (a > 1.0) ? a : 1.0;
    for (int k = 0; k < 60; k++) s = 0.5 * (s + a / s);
    return s;
  endfunction

  // Taylor series is fine for 2^-n <= 0.5; n = 0 is the exact pi/4.
  function automatic real atan_r(input int n);
    real t, t2, term, sum;
    if (n == 0) return PI_R / 4.0;
    t    = pow2_neg(n);
    t2   = t * t;
    term = t;
    sum  = 0.0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
      else            sum = sum - term / real'(2 * k + 1);
      term = term * t2;
    end
    return sum;
  endfunction

  function automatic real gain_r(input int n);
    real p;
    p = 1.0;
    for (int k = 0; k < n; k++) p = p * (1.0 + pow2_neg(2 * k));
    return 1.0 / sqrt_r(p);
  endfunction

  function automatic longint to_fx(input real r);
    real sc;
    sc = 1.0;
    for (int k = 0; k < int'(FRAC); k++) sc = sc * 2.0;
    return longint'(r * sc);
  endfunction

  localparam logic signed [IW-1:0] KGAIN   = IW'(to_fx(gain_r(ITER)));
  localparam logic signed [IW-1:0] PI_FX   = IW'(to_fx(PI_R));
  localparam logic signed [IW-1:0] HALF_PI = IW'(to_fx(PI_R / 2.0));
  localparam logic signed [IW-1:0] ONE     = {{(IW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [IW-1:0] NEG_ONE = -ONE;

  if (ITER % FOLD != 0) begin : g_chk_fold
    $error("cordic_sincos_folded: ITER must be a multiple of FOLD");
  end
  if (ITER < 1 || ITER > WIDTH - 2) begin : g_chk_iter
    $error("cordic_sincos_folded: ITER must be within 1..WIDTH-2");
  end

  // Table padded to a power of two so the count-based index never leaves it.
  logic signed [IW-1:0] w_atan_tab [TN];
  for (genvar g = 0; g < TN; g++) begin : g_atan
    if (g < ITER) begin : g_ent
      localparam logic signed [IW-1:0] ATAN = IW'(to_fx(atan_r(g)));
      assign w_atan_tab[g] = ATAN;
    end else begin : g_pad
      assign w_atan_tab[g] = '0;
    end
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               r_state;
  logic [CW-1:0]        r_count;
  logic signed [IW-1:0] r_x, r_y, r_z;
  logic                 r_neg, r_sel, r_busy, r_done;
  logic [WIDTH-1:0]     r_cos, r_sin, r_result;

  logic signed [IW-1:0] w_z_ext, w_z_fold;
  logic                 w_neg;
  logic signed [IW-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
  logic signed [IW-1:0] w_cos_raw, w_sin_raw;
  logic [WIDTH-1:0]     w_cos_sat, w_sin_sat;
  logic                 w_last;

  function automatic logic [WIDTH-1:0] sat_q(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] c;
    if (v > ONE)          c = ONE;
    else if (v < NEG_ONE) c = NEG_ONE;
    else                  c = v;
    return c[WIDTH-1:0];
  endfunction

  assign w_z_ext = {{2{i_z_in[WIDTH-1]}}, i_z_in};

  always_comb begin
    w_z_fold = w_z_ext;
    w_neg    = 1'b0;
    if (w_z_ext > HALF_PI) begin
      w_z_fold = w_z_ext - PI_FX;
      w_neg    = 1'b1;
    end else if (w_z_ext < -HALF_PI) begin
      w_z_fold = w_z_ext + PI_FX;
      w_neg    = 1'b1;
    end
  end

  always_comb begin : p_chain
    logic signed [IW-1:0] x_v, y_v, z_v, xs, ys;
    logic [CW-1:0]        idx;
    x_v = r_x;
    y_v = r_y;
    z_v = r_z;
    xs  = '0;
    ys  = '0;
    idx = '0;
    for (int j = 0; j < int'(FOLD); j++) begin
      idx = r_count + CW'(j);
      xs  = x_v >>> idx;
      ys  = y_v >>> idx;
      if (!z_v[IW-1]) begin
        x_v = x_v - ys;
        y_v = y_v + xs;
        z_v = z_v - w_atan_tab[idx];
      end else begin
        x_v = x_v + ys;
        y_v = y_v - xs;
        z_v = z_v + w_atan_tab[idx];
      end
    end
    w_x_nxt = x_v;
    w_y_nxt = y_v;
    w_z_nxt = z_v;
  end

  assign w_last    = (r_count == CW'(ITER - FOLD));
  assign w_cos_raw = r_neg ? -w_x_nxt : w_x_nxt;
  assign w_sin_raw = r_neg ? -w_y_nxt : w_y_nxt;
  assign w_cos_sat = sat_q(w_cos_raw);
  assign w_sin_sat = sat_q(w_sin_raw);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_neg    <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_result <= '0;
    end else if (i_clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_sel   <= i_res_sel;
            r_x     <= KGAIN;
            r_y     <= '0;
            r_z     <= w_z_fold;
            r_neg   <= w_neg;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_x     <= w_x_nxt;
          r_y     <= w_y_nxt;
          r_z     <= w_z_nxt;
          r_count <= r_count + CW'(FOLD);
          if (w_last) begin
            r_cos    <= w_cos_sat;
            r_sin    <= w_sin_sat;
            r_result <= r_sel ? w_sin_sat : w_cos_sat;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cos_out = r_cos;
  assign o_sin_out = r_sin;
  assign o_result  = r_result;

endmodule

// File: tb/tb_cordic_sincos_folded.sv
// Bench for cordic_sincos_folded: directed operations with a queue of real-math expected results.
`timescale 1ns/1ps
module tb_cordic_sincos_folded;

  localparam int TOL = 256;
  localparam int ONE = 4194304;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] z = '0;
  logic        busy, done;
  logic [23:0] cos_out, sin_out, result;

  int errors = 0;
  int checks = 0;
  int n;

  typedef struct {int c; int s; logic sel;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cordic_sincos_folded #(
    .WIDTH(24),
    .FRAC (22),
    .ITER (16),
    .FOLD (4)
  ) u_dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_clk_en (clk_en),
    .i_start  (start),
    .i_res_sel(sel),
    .i_z_in   (z),
    .o_busy   (busy),
    .o_done   (done),
    .o_cos_out(cos_out),
    .o_sin_out(sin_out),
    .o_result (result)
  );

  function automatic int fx(input real r);
    int v;
    v = int'(r * 4194304.0);
    if (v > ONE) v = ONE;
    if (v < -ONE) v = -ONE;
    return v;
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int want);
    checks++;
    assert ((obs - want) <= TOL && (want - obs) <= TOL) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (+/-%0d)", tag, obs, want, TOL);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [23:0] zz, input logic s);
    real zr;
    zr = real'($signed(zz)) / 4194304.0;
    sb.push_back('{fx($cos(zr)), fx($sin(zr)), s});
  endtask

  task automatic launch(input logic [23:0] zz, input logic s);
    z     = zz;
    sel   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int nn);
    nn = n0;
    while (done !== 1'b1 && nn < 40) begin
      tick();
      nn++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk_near({tag, "_cos"}, int'($signed(cos_out)), e.c);
      chk_near({tag, "_sin"}, int'($signed(sin_out)), e.s);
      chk_near({tag, "_result"}, int'($signed(result)), e.sel ? e.s : e.c);
      chk_eq({tag, "_busy_at_done"}, int'(busy), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk_eq({tag, "_busy"}, int'(busy), 0);
    chk_eq({tag, "_done"}, int'(done), 0);
    chk_eq({tag, "_cos"}, int'(cos_out), 0);
    chk_eq({tag, "_sin"}, int'(sin_out), 0);
    chk_eq({tag, "_result"}, int'(result), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_zero("reset");
    #4 rst_n = 1'b1;
    tick();

    // z = 0, cos selected
    expect_op(24'h000000, 1'b0);
    launch(24'h000000, 1'b0);
    wait_done(0, n);
    chk_eq("lat_zero", n, 4);
    check_result("zero");
    tick();
    chk_eq("done_pulse", int'(done), 0);

    expect_op(24'h3243F7, 1'b0);
    launch(24'h3243F7, 1'b0);
    wait_done(0, n);
    chk_eq("lat_pi4", n, 4);
    check_result("pi4");

    expect_op(24'hCDBC09, 1'b1);
    launch(24'hCDBC09, 1'b1);
    wait_done(0, n);
    check_result("neg_pi4");

    // 1.9 rad needs the quadrant fold
    expect_op(24'h799999, 1'b1);
    launch(24'h799999, 1'b1);
    wait_done(0, n);
    chk_eq("lat_fold", n, 4);
    check_result("fold_1p9");

    expect_op(24'h6487ED, 1'b1);
    launch(24'h6487ED, 1'b1);
    wait_done(0, n);
    check_result("pi2");
    chk_eq("pi2_sat", int'(int'($signed(sin_out)) <= ONE), 1);

    // start while busy is ignored
    expect_op(24'h3243F7, 1'b0);
    launch(24'h3243F7, 1'b0);
    z     = 24'h799999;
    sel   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done(2, n);
    chk_eq("lat_busy_ign", n, 4);
    check_result("busy_ign");
    repeat (3) tick();
    chk_eq("no_restart_busy", int'(busy), 0);
    chk_eq("no_restart_done", int'(done), 0);

    // clk_en low for 3 cycles mid-run
    expect_op(24'h1A0000, 1'b0);
    launch(24'h1A0000, 1'b0);
    tick();
    clk_en = 1'b0;
    repeat (3) tick();
    chk_eq("stall_busy", int'(busy), 1);
    clk_en = 1'b1;
    wait_done(4, n);
    chk_eq("lat_stall", n, 7);
    check_result("stall");

    // back-to-back: start accepted on the edge after done
    expect_op(24'h200000, 1'b0);
    launch(24'h200000, 1'b0);
    wait_done(0, n);
    check_result("b2b_a");
    expect_op(24'hE00000, 1'b1);
    launch(24'hE00000, 1'b1);
    chk_eq("b2b_done_clr", int'(done), 0);
    chk_eq("b2b_busy", int'(busy), 1);
    wait_done(0, n);
    chk_eq("lat_b2b", n, 4);
    check_result("b2b_b");

    // asynchronous reset mid-run
    launch(24'h799999, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    #3 rst_n = 1'b1;
    tick();
    expect_op(24'h100000, 1'b1);
    launch(24'h100000, 1'b1);
    wait_done(0, n);
    chk_eq("lat_after_abort", n, 4);
    check_result("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
